// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired zero register, write-to-read bypass,
// per-register busy scoreboard and a one-entry-per-cycle clear sequencer.
module reg_file_mp #(
    parameter int WORD_LEN   = 32,
    parameter int ADDR_LEN   = 5,
    parameter int WORD_COUNT = 2**ADDR_LEN,
    parameter int READ_PORTS = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [READ_PORTS*ADDR_LEN-1:0] rd_addr,
    output logic [READ_PORTS*WORD_LEN-1:0] rd_data,
    output logic [READ_PORTS-1:0]          rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_LEN-1:0]            wr_addr,
    input  logic [WORD_LEN-1:0]            wr_data,
    input  logic                           rsv_en,
    input  logic [ADDR_LEN-1:0]            rsv_addr,
    input  logic                           clear_req,
    output logic                           ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_LEN-1:0]   cnt;
    logic [ADDR_LEN-1:0]   cnt_next;
    logic [WORD_COUNT-1:0] busy;
    logic [WORD_COUNT-1:0] busy_next;
    logic [WORD_LEN-1:0]   mem [WORD_COUNT];
    logic                  cnt_last;
    logic                  wr_fire;
    logic                  rsv_fire;

    function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
        return (int'(a) < WORD_COUNT);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_LEN-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Only real, non-zero registers can be written or reserved.
    function automatic logic writable(input logic [ADDR_LEN-1:0] a);
        return in_range(a) && !is_zero_reg(a);
    endfunction

    assign cnt_last = (cnt == ADDR_LEN'(WORD_COUNT - 1));

    // A clear request in the same cycle swallows any write or reservation.
    assign wr_fire  = ready && wr_en  && !clear_req && writable(wr_addr);
    assign rsv_fire = ready && rsv_en && !clear_req && writable(rsv_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready      = 1'b0;
        case (state)
            CLEAR: begin
                if (cnt_last) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN: begin
                ready = 1'b1;
                if (clear_req) begin
                    cnt_next   = '0;
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Reservation is applied after the write so a same-cycle reserve leaves the entry busy.
    always_comb begin
        busy_next = busy;
        if (state != RUN || clear_req) begin
            busy_next = '0;
        end else begin
            if (wr_fire) begin
                busy_next[wr_addr] = 1'b0;
            end
            if (rsv_fire) begin
                busy_next[rsv_addr] = 1'b1;
            end
        end
    end

    // Storage has no reset; the sweep zeroes it one entry per edge.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        logic [ADDR_LEN-1:0] addr;
        logic [WORD_LEN-1:0] data;
        logic                bsy;

        assign addr = rd_addr[i*ADDR_LEN +: ADDR_LEN];

        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (state == RUN && in_range(addr) && !is_zero_reg(addr)) begin
                if (BYPASS && wr_fire && (wr_addr == addr)) begin
                    data = wr_data;
                end else begin
                    data = mem[addr];
                    bsy  = busy[addr];
                end
            end
        end

        assign rd_data[i*WORD_LEN +: WORD_LEN] = data;
        assign rd_busy[i]                      = bsy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp, checked every cycle against
// a behavioural model of the register file (countdown clear, array storage).
module tb_reg_file_mp;

    localparam int WL = 32;
    localparam int AL = 5;
    localparam int WC = 32;
    localparam int RP = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [RP*AL-1:0]    rd_addr = '0;
    logic [RP*WL-1:0]    rd_data;
    logic [RP-1:0]       rd_busy;
    logic                wr_en = 1'b0;
    logic [AL-1:0]       wr_addr = '0;
    logic [WL-1:0]       wr_data = '0;
    logic                rsv_en = 1'b0;
    logic [AL-1:0]       rsv_addr = '0;
    logic                clear_req = 1'b0;
    logic                ready;

    int n_checks = 0;
    int n_pass   = 0;
    bit en_cmp   = 1'b0;

    // Behavioural model: edges left in the current clear, storage and busy flags.
    int          left = WC;
    logic [WL-1:0] mem_m [WC];
    logic [WC-1:0] busy_m = '0;

    reg_file_mp #(
        .WORD_LEN(WL), .ADDR_LEN(AL), .WORD_COUNT(WC),
        .READ_PORTS(RP), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clear_req(clear_req), .ready(ready)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            left   <= WC;
            busy_m <= '0;
        end else if (left != 0) begin
            if (left == 1) begin
                for (int k = 0; k < WC; k++) mem_m[k] <= '0;
            end
            left <= left - 1;
        end else if (clear_req) begin
            left   <= WC;
            busy_m <= '0;
        end else begin
            if (wr_en && wr_addr != 0) begin
                mem_m[wr_addr]  <= wr_data;
                busy_m[wr_addr] <= 1'b0;
            end
            if (rsv_en && rsv_addr != 0) busy_m[rsv_addr] <= 1'b1;
        end
    end

    function automatic void model_read(input logic [AL-1:0] a, output logic [WL-1:0] d,
                                       output logic b);
        d = '0;
        b = 1'b0;
        if (left == 0 && a != 0) begin
            if (wr_en && !clear_req && wr_addr == a) begin
                d = wr_data;
            end else begin
                d = mem_m[a];
                b = busy_m[a];
            end
        end
    endfunction

    always @(negedge clk) begin
        if (en_cmp) begin
            logic [WL-1:0] ed;
            logic          eb;
            chk("ready", {31'b0, ready}, {31'b0, (left == 0)});
            for (int p = 0; p < RP; p++) begin
                model_read(rd_addr[p*AL +: AL], ed, eb);
                chk($sformatf("rd_data%0d", p), rd_data[p*WL +: WL], ed);
                chk($sformatf("rd_busy%0d", p), {31'b0, rd_busy[p]}, {31'b0, eb});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AL-1:0] a);
        rd_addr[p*AL +: AL] = a;
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic wait_clear(input string tag);
        repeat (31) step();
        chk({tag, "_ready_at_31"}, {31'b0, ready}, 32'd0);
        step();
        chk({tag, "_ready_at_32"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        #3 rst = 1'b0;
        #1 en_cmp = 1'b1;
        step();
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_rd_data", rd_data[WL-1:0], 32'd0);
        step();
        rst = 1'b1;
        wait_clear("init");

        // Every register reads zero and idle after the initial sweep.
        for (int a = 0; a < WC; a++) begin
            step();
            set_rd(0, AL'(a));
            set_rd(1, AL'(WC - 1 - a));
            #2;
            chk("sweep_zero", rd_data[WL-1:0], 32'd0);
        end
        chk("sweep_busy", {30'b0, rd_busy}, 32'd0);

        // Bypass of a same-cycle write, then the stored value.
        step();
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(0, 5);
        #2 chk("bypass_r5", rd_data[WL-1:0], 32'hDEADBEEF);
        step();
        idle();
        #2 chk("stored_r5", rd_data[WL-1:0], 32'hDEADBEEF);

        // Zero register ignores writes and reservations.
        step();
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 0; set_rd(0, 0); set_rd(1, 0);
        #2 chk("r0_bypass_blocked", rd_data[2*WL-1:WL], 32'd0);
        step();
        idle();
        #2 chk("r0_reads_zero", rd_data[WL-1:0], 32'd0);
        chk("r0_not_busy", {30'b0, rd_busy}, 32'd0);

        // Reservation wins over a same-cycle write; plain write clears busy.
        step();
        rsv_en = 1'b1; rsv_addr = 7; set_rd(0, 7);
        step();
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5;
        step();
        idle();
        #2 chk("r7_data_a5", rd_data[WL-1:0], 32'hA5);
        chk("r7_busy_set", {31'b0, rd_busy[0]}, 32'd1);
        step();
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h5A;
        step();
        idle();
        #2 chk("r7_data_5a", rd_data[WL-1:0], 32'h5A);
        chk("r7_busy_clr", {31'b0, rd_busy[0]}, 32'd0);

        // Clear request drops a simultaneous write and wipes file and busy flags.
        for (int r = 1; r <= 3; r++) begin
            step();
            wr_en = 1'b1; wr_addr = AL'(r); wr_data = WL'(r);
        end
        step();
        wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 2;
        step();
        rsv_en = 1'b0; clear_req = 1'b1; wr_en = 1'b1; wr_addr = 4; wr_data = 32'h4;
        step();
        idle();
        wait_clear("clear_req");
        for (int r = 1; r <= 4; r++) begin
            step();
            set_rd(0, AL'(r)); set_rd(1, AL'(r));
            #2 chk("post_clear_data", rd_data[WL-1:0], 32'd0);
            chk("post_clear_busy", {30'b0, rd_busy}, 32'd0);
        end

        // Reset in the middle of a sweep restarts it from the beginning.
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (10) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (22) step();
        chk("midreset_not_22", {31'b0, ready}, 32'd0);
        repeat (9) step();
        chk("midreset_ready_at_31", {31'b0, ready}, 32'd0);
        step();
        chk("midreset_ready_at_32", {31'b0, ready}, 32'd1);

        // Random traffic with hot addresses to exercise bypass and busy.
        for (int n = 0; n < 2500; n++) begin
            step();
            rst       = ($urandom_range(0, 699) != 0);
            clear_req = ($urandom_range(0, 149) == 0);
            wr_en     = $urandom_range(0, 1);
            wr_addr   = ($urandom_range(0, 1) != 0) ? AL'($urandom_range(0, 7)) : AL'($urandom_range(0, WC - 1));
            wr_data   = $urandom;
            rsv_en    = ($urandom_range(0, 2) == 0);
            rsv_addr  = ($urandom_range(0, 1) != 0) ? AL'($urandom_range(0, 7)) : wr_addr;
            set_rd(0, ($urandom_range(0, 3) == 0) ? wr_addr : AL'($urandom_range(0, 7)));
            set_rd(1, AL'($urandom_range(0, WC - 1)));
        end
        step();
        rst = 1'b1;
        idle();
        repeat (3) step();
        en_cmp = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
